// File: rtl/lut_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : lut_seq_if
// Description : Frame handshake and ROM port bundle of lut_layer_sequencer.
//               The slave modport is the sequencer's view; master is the host/ROM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface lut_seq_if #(
    parameter int IN_FEATURES = 64,
    parameter int OUT_NEURONS = 16,
    parameter int FANIN       = 4,
    parameter int BW          = 2,
    parameter int IDX_W       = $clog2(IN_FEATURES),
    parameter int NIDX_W      = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1
);
    logic                          in_valid;
    logic                          in_ready;
    logic [IN_FEATURES*BW-1:0]     in_data;
    logic                          conn_rd_en;
    logic [NIDX_W-1:0]             conn_addr;
    logic [FANIN*IDX_W-1:0]        conn_data;
    logic                          lut_rd_en;
    logic [NIDX_W+FANIN*BW-1:0]    lut_addr;
    logic [BW-1:0]                 lut_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [OUT_NEURONS*BW-1:0]     out_data;
    logic                          cfg_err;

    modport slave (
        input  in_valid, in_data, conn_data, lut_data, out_ready,
        output in_ready, conn_rd_en, conn_addr, lut_rd_en, lut_addr,
               out_valid, out_data, cfg_err
    );

    modport master (
        output in_valid, in_data, conn_data, lut_data, out_ready,
        input  in_ready, conn_rd_en, conn_addr, lut_rd_en, lut_addr,
               out_valid, out_data, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/lut_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lut_layer_sequencer
// Description : Evaluates a LogicNets layer one neuron per cycle through shared
//               connectivity and truth-table ROM ports. Define LUT_SEQ_PERF_EN
//               to add the perf_frames / perf_stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_layer_sequencer #(
    parameter int IN_FEATURES = 64,
    parameter int OUT_NEURONS = 16,
    parameter int FANIN       = 4,
    parameter int BW          = 2,
    parameter int IDX_W       = $clog2(IN_FEATURES),
    parameter int NIDX_W      = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
`ifdef LUT_SEQ_PERF_EN
    output logic [31:0] perf_frames,
    output logic [31:0] perf_stall,
`endif
    lut_seq_if.slave    bus
);
    localparam int c_GATH_W = FANIN * BW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IN_FEATURES*BW-1:0]  r_in;
    logic [NIDX_W-1:0]          r_n;
    logic [NIDX_W-1:0]          r_n1;
    logic [NIDX_W-1:0]          r_n2;
    logic                       r_v1;
    logic                       r_v2;
    logic                       r_in_ready;
    logic [OUT_NEURONS*BW-1:0]  r_out_data;
    logic                       r_cfg_err;
    logic                       w_accept;
    logic                       w_last_issue;
    logic [c_GATH_W-1:0]        w_gathered;
    logic [FANIN-1:0]           w_idx_ok;

    assign w_accept     = (r_state == S_IDLE) && r_in_ready && bus.in_valid;
    assign w_last_issue = (r_n == NIDX_W'(OUT_NEURONS - 1));

    // Per-slot feature select; an out-of-range index gathers zero and flags the slot.
    generate
        for (genvar k = 0; k < FANIN; k++) begin : g_slot
            logic [IDX_W-1:0] w_idx;
            logic [BW-1:0]    w_pick;
            logic             w_hit;

            assign w_idx = bus.conn_data[k*IDX_W +: IDX_W];

            always_comb begin
                w_pick = '0;
                w_hit  = 1'b0;
                for (int f = 0; f < IN_FEATURES; f++) begin
                    if (w_idx == IDX_W'(f)) begin
                        w_pick = r_in[f*BW +: BW];
                        w_hit  = 1'b1;
                    end
                end
            end

            assign w_gathered[k*BW +: BW] = w_pick;
            assign w_idx_ok[k]            = w_hit;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)       w_state_nxt = S_RUN;
            S_RUN:   if (w_last_issue)   w_state_nxt = S_DRAIN;
            // r_v1 low means the final lookup is in flight and lands this edge.
            S_DRAIN: if (!r_v1)          w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready)  w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_in       <= '0;
            r_n        <= '0;
            r_n1       <= '0;
            r_n2       <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == S_IDLE);
            r_v1       <= (r_state == S_RUN);
            r_n1       <= r_n;
            r_v2       <= r_v1;
            r_n2       <= r_n1;
            if (w_accept) begin
                r_in <= bus.in_data;
                r_n  <= '0;
            end else if (r_state == S_RUN) begin
                r_n  <= r_n + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            if (r_v1 && !(&w_idx_ok)) begin
                r_cfg_err <= 1'b1;
            end
            if (r_v2) begin
                for (int n = 0; n < OUT_NEURONS; n++) begin
                    if (r_n2 == NIDX_W'(n)) begin
                        r_out_data[n*BW +: BW] <= bus.lut_data;
                    end
                end
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.conn_rd_en = (r_state == S_RUN);
    assign bus.conn_addr  = (r_state == S_RUN) ? r_n : '0;
    assign bus.lut_rd_en  = r_v1;
    assign bus.lut_addr   = r_v1 ? {r_n1, w_gathered} : '0;
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.out_data   = r_out_data;
    assign bus.cfg_err    = r_cfg_err;

`ifdef LUT_SEQ_PERF_EN
    logic [31:0] r_perf_frames;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_frames <= '0;
            r_perf_stall  <= '0;
        end else begin
            if ((r_state == S_DONE) && bus.out_ready) begin
                r_perf_frames <= r_perf_frames + 32'd1;
            end
            if ((r_state == S_DONE) && !bus.out_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_frames = r_perf_frames;
    assign perf_stall  = r_perf_stall;
`endif
endmodule
`default_nettype wire
